// File: rtl/ctrl_pkg.sv
// Shared multicycle CPU control encodings: state codes, opcodes and datapath mux/ALU selects.
// The controller and the datapath both import this package.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_is_legal = 1'b1;
            default:                                        op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction opcode and memory handshake in, control strobes out.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op
    );

endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style controller: one state register, outputs decoded combinationally from it.
// Reset also gates the outputs so nothing fires while rst is held.
module multicycle_control
    import ctrl_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.master bus
);

    state_t state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:    if (bus.mem_ready) state_q <= DECODE;
                DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state_q <= MEM_ADDR;
                        OP_RTYPE:     state_q <= EXEC;
                        OP_BEQ:       state_q <= BRANCH;
                        OP_J:         state_q <= JUMP;
                        OP_ADDI:      state_q <= ADDI_EX;
                        default:      state_q <= FETCH;
                    endcase
                end
                MEM_ADDR: state_q <= (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   if (bus.mem_ready) state_q <= MEM_WB;
                MEM_WR:   if (bus.mem_ready) state_q <= FETCH;
                EXEC:     state_q <= R_WB;
                ADDI_EX:  state_q <= ADDI_WB;
                // MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB and unused codes all return to FETCH
                default:  state_q <= FETCH;
            endcase
        end
    end

    assign bus.state = rst ? 4'd0 : state_q;

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = PC_ALU;
        bus.illegal_op    = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                DECODE: begin
                    bus.alu_src_b  = SRCB_IMM_SHL;
                    bus.illegal_op = !op_is_legal(bus.opcode);
                end
                MEM_ADDR, ADDI_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                end
                MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                end
                MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_FUNCT;
                end
                R_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALU_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = PC_ALUOUT;
                end
                JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PC_JUMP;
                end
                ADDI_WB: bus.reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 opcode  in  6  instruction-register bits [31:26].
REQ-004 mem_ready  in  1  memory completes the current read/write this cycle.
REQ-005 pc_write, pc_write_cond  out  1 each  PC unconditional / branch-conditional write enables.
REQ-006 iord, mem_read, mem_write, ir_write  out  1 each  memory address select (0=PC, 1=ALUOut), memory strobes, IR load.
REQ-007 reg_dst, mem_to_reg, reg_write  out  1 each  register-file write controls.
REQ-008 alu_src_a  out  1; alu_src_b  out  2; alu_op  out  2; pc_source  out  2  datapath mux and ALU controls.
REQ-009 state  out  4  current state code, for debug; illegal_op  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-010 Decoded opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000; all others are illegal.
REQ-011 States and codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
REQ-012 Outputs are a decode of the state register, gated by mem_ready only where stated; no output is registered.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=1 and pc_write=1 only when mem_ready=1; the FSM holds in FETCH while mem_ready=0 and moves to DECODE when mem_ready=1.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state: lw/sw -> MEM_ADDR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDI_EX; illegal -> FETCH with illegal_op=1 for that cycle.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: lw -> MEM_RD; sw -> MEM_WR.
REQ-016 MEM_RD: mem_read=1, iord=1; the FSM holds while mem_ready=0, then moves to MEM_WB.
REQ-017 MEM_WR: mem_write=1, iord=1; the FSM holds while mem_ready=0, then moves to FETCH.
REQ-018 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH.
REQ-021 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-022 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-023 Every output not listed for a state is 0 in that state.
REQ-024 Instruction latency with mem_ready held at 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3. Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
REQ-025 An unused state code (12-15) returns to FETCH on the next edge with all outputs 0.
REQ-026 opcode is sampled only in DECODE and MEM_ADDR; changes to opcode in other states have no effect.

Reset
REQ-027 When rst=1 at a clock edge, the state becomes FETCH, regardless of the current state or a pending memory wait.
REQ-028 While rst=1, all control outputs and illegal_op are forced to 0; state reads 0.

Structure
REQ-029 The state codes, opcode constants, alu_op and pc_source encodings are defined in a shared package, ctrl_pkg, which the datapath also uses.
REQ-030 The design is one module containing a state register and a combinational next-state/output decode; there are no sub-modules.

Verification
REQ-031 Reset: rst=1 for 2 cycles from EXEC -> state=0 and all outputs 0; after release, mem_read=1 in the first cycle.
REQ-032 lw with mem_ready=1: opcode=100011 -> state sequence 0,1,2,3,4,0 over 5 cycles; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-033 Wait states: sw with mem_ready=0 for 3 cycles in MEM_WR -> state 5 held 4 cycles with mem_write=1; total 7 cycles; ir_write=0 during FETCH wait cycles.
REQ-034 beq then j: opcode=000100 -> pc_write_cond=1 and pc_source=01 in state 8; opcode=000010 -> pc_write=1 and pc_source=10 in state 9; each takes 3 cycles.
REQ-035 Illegal opcode 111111 -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH, and no reg_write or mem_write at any point.
REQ-036 Mid-instruction reset: rst asserted in MEM_RD with mem_ready=0 -> FETCH on the next edge and no reg_write pulse.
